// File: rtl/string_match_counter_pkg.sv
// Shared types and constants for the needle/haystack match counter.
// The state encodings are fixed because other blocks in the stream path decode them.
package string_match_counter_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_NEEDLE   = 2'd0,
      ST_HAYSTACK = 2'd1,
      ST_EMIT     = 2'd2
   } state_e;

   // An index into an n-entry table, kept at least one bit wide
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/string_match_counter_window.sv
// Needle register file, sliding haystack window and fill counter, plus the
// combinational match flag for the byte currently being shifted in.
module string_match_counter_window
   import string_match_counter_pkg::*;
#(
   parameter int STRING_SIZE = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_needle_we,
   input  logic              i_shift_en,
   input  logic [BYTE_W-1:0] i_byte,
   output logic              o_needle_done,
   output logic              o_match
);

   localparam int IDX_W  = idx_width(STRING_SIZE);
   localparam int FILL_W = $clog2(STRING_SIZE + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STRING_SIZE - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(STRING_SIZE);

   logic [STRING_SIZE-1:0][BYTE_W-1:0] r_needle;
   logic [STRING_SIZE-1:0][BYTE_W-1:0] r_window;
   logic [STRING_SIZE-1:0][BYTE_W-1:0] w_window_next;
   logic [IDX_W-1:0]                   r_idx;
   logic [FILL_W-1:0]                  r_fill;
   logic [FILL_W-1:0]                  w_fill_next;

   // Oldest byte sits at [0]; the incoming byte lands at [STRING_SIZE-1]
   always_comb begin
      for (int i = 0; i < STRING_SIZE - 1; i++) begin
         w_window_next[i] = r_window[i+1];
      end
      w_window_next[STRING_SIZE-1] = i_byte;
   end

   assign w_fill_next   = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
   assign o_needle_done = (r_idx == IDX_LAST);
   assign o_match       = i_shift_en && (w_fill_next == FILL_FULL) && (w_window_next == r_needle);

   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_needle <= '0;
         r_window <= '0;
         r_idx    <= '0;
         r_fill   <= '0;
      end else begin
         if (i_needle_we) begin
            r_needle[r_idx] <= i_byte;
            r_idx           <= o_needle_done ? '0 : r_idx + 1'b1;
         end
         if (i_shift_en) begin
            r_window <= w_window_next;
            r_fill   <= w_fill_next;
         end
      end
   end

endmodule

// File: rtl/string_match_counter.sv
// Counts needle occurrences (overlaps included) in each haystack frame and
// returns the saturating count as a little-endian byte frame.
module string_match_counter
   import string_match_counter_pkg::*;
#(
   parameter int STRING_SIZE = 5,
   parameter int COUNT_BYTES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   localparam int CNT_W = BYTE_W * COUNT_BYTES;
   localparam int E_W   = idx_width(COUNT_BYTES);
   localparam logic [E_W-1:0]   E_LAST  = E_W'(COUNT_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   state_e            r_state;
   state_e            w_state_next;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_next;
   logic [CNT_W-1:0]  w_count_shift;
   logic [E_W-1:0]    r_e;
   logic              w_accept;
   logic              w_out_fire;
   logic              w_emit_done;
   logic              w_needle_done;
   logic              w_match;

   assign w_accept      = in_valid && in_ready && (r_state != ST_EMIT);
   assign w_out_fire    = out_valid && out_ready;
   assign w_emit_done   = w_out_fire && (r_state == ST_EMIT) && (r_e == E_LAST);
   assign w_count_next  = w_match ? sat_inc(r_count) : r_count;
   assign w_count_shift = r_count >> (BYTE_W * (int'(r_e) + 1));

   string_match_counter_window #(
      .STRING_SIZE (STRING_SIZE)
   ) u_window (
      .clock         (clock),
      .reset         (reset),
      .i_clear       (w_emit_done),
      .i_needle_we   (w_accept && (r_state == ST_NEEDLE)),
      .i_shift_en    (w_accept && (r_state == ST_HAYSTACK)),
      .i_byte        (in_data),
      .o_needle_done (w_needle_done),
      .o_match       (w_match)
   );

   // A last byte arriving while the needle is still loading ends the frame with count zero
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_NEEDLE: begin
            if (w_accept) begin
               if (in_last)            w_state_next = ST_EMIT;
               else if (w_needle_done) w_state_next = ST_HAYSTACK;
            end
         end
         ST_HAYSTACK: if (w_accept && in_last) w_state_next = ST_EMIT;
         ST_EMIT:     if (w_emit_done)         w_state_next = ST_NEEDLE;
         default:                              w_state_next = ST_NEEDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_NEEDLE;
         r_count   <= '0;
         r_e       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         r_state  <= w_state_next;
         // Looking at the next state keeps in_ready low on the very first EMIT cycle
         in_ready <= enable && (w_state_next != ST_EMIT);
         case (r_state)
            ST_NEEDLE: begin
               if (w_accept && in_last) begin
                  r_count   <= '0;
                  r_e       <= '0;
                  out_valid <= 1'b1;
                  out_data  <= '0;
                  out_last  <= (E_LAST == '0);
               end
            end
            ST_HAYSTACK: begin
               if (w_accept) begin
                  r_count <= w_count_next;
                  if (in_last) begin
                     r_e       <= '0;
                     out_valid <= 1'b1;
                     out_data  <= w_count_next[BYTE_W-1:0];
                     out_last  <= (E_LAST == '0);
                  end
               end
            end
            ST_EMIT: begin
               if (w_out_fire) begin
                  if (r_e == E_LAST) begin
                     r_count   <= '0;
                     r_e       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_data  <= '0;
                  end else begin
                     r_e      <= r_e + 1'b1;
                     out_data <= w_count_shift[BYTE_W-1:0];
                     out_last <= ((r_e + 1'b1) == E_LAST);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_string_match_counter.sv
// Bench for string_match_counter: directed frames plus random frames checked
// against a brute-force occurrence count; a second instance uses a one-byte counter.
`timescale 1ns/1ps
module tb_string_match_counter;

   localparam int SS     = 5;
   localparam int BUDGET = 1000;

   typedef logic [7:0] bq_t[$];

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_valid_a = 1'b0;
   logic       in_valid_b = 1'b0;
   logic       in_ready_a, out_valid_a, out_last_a;
   logic       in_ready_b, out_valid_b, out_last_b;
   logic [7:0] out_data_a, out_data_b;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   string_match_counter #(.STRING_SIZE(SS), .COUNT_BYTES(2)) dut_a (
      .clock(clock), .reset(reset), .enable(enable),
      .in_data(in_data), .in_valid(in_valid_a), .in_last(in_last), .in_ready(in_ready_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_last(out_last_a), .out_ready(out_ready)
   );

   string_match_counter #(.STRING_SIZE(SS), .COUNT_BYTES(1)) dut_b (
      .clock(clock), .reset(reset), .enable(enable),
      .in_data(in_data), .in_valid(in_valid_b), .in_last(in_last), .in_ready(in_ready_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_last(out_last_b), .out_ready(out_ready)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required frames to complete");
      $fatal(1, "watchdog");
   end

   function automatic logic f_in_ready(input bit sel);
      return sel ? in_ready_b : in_ready_a;
   endfunction
   function automatic logic f_out_valid(input bit sel);
      return sel ? out_valid_b : out_valid_a;
   endfunction
   function automatic logic f_out_last(input bit sel);
      return sel ? out_last_b : out_last_a;
   endfunction
   function automatic logic [7:0] f_out_data(input bit sel);
      return sel ? out_data_b : out_data_a;
   endfunction

   task automatic set_valid(input bit sel, input logic v);
      if (sel) in_valid_b = v;
      else     in_valid_a = v;
   endtask

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
      return q;
   endfunction

   function automatic bq_t cat(input bq_t a, input bq_t b);
      bq_t q;
      q = a;
      for (int i = 0; i < b.size(); i++) q.push_back(b[i]);
      return q;
   endfunction

   function automatic bq_t rep(input logic [7:0] c, input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(c);
      return q;
   endfunction

   // Reference: slide the needle over every haystack start position and count hits
   function automatic int model_count(input bq_t f, input int cb);
      int cnt;
      int maxv;
      bit hit;
      cnt  = 0;
      maxv = (1 << (8 * cb)) - 1;
      if (f.size() <= SS) return 0;
      for (int p = SS; p + SS <= f.size(); p++) begin
         hit = 1'b1;
         for (int k = 0; k < SS; k++) if (f[p+k] != f[k]) hit = 1'b0;
         if (hit && cnt < maxv) cnt++;
      end
      return cnt;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_accept(input bit sel);
      int n;
      n = 0;
      while (!f_in_ready(sel)) begin
         @(negedge clock);
         n++;
         if (n > BUDGET) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready observed 0 expected 1");
            $fatal(1, "accept timeout");
         end
      end
      @(negedge clock);
   endtask

   task automatic send_frame(input bit sel, input bq_t f, input bit with_last, input bit gaps);
      int g;
      for (int i = 0; i < f.size(); i++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               enable = 1'($urandom_range(0, 1));
               @(negedge clock);
            end
            enable = 1'b1;
         end
         in_data = f[i];
         in_last = with_last && (i == f.size() - 1);
         set_valid(sel, 1'b1);
         wait_accept(sel);
         set_valid(sel, 1'b0);
         in_last = 1'b0;
      end
   endtask

   task automatic recv_frame(input bit sel, input int cnt, input int stall);
      int         cb;
      int         n;
      logic [7:0] eb;
      cb = sel ? 1 : 2;
      for (int e = 0; e < cb; e++) begin
         eb = 8'((cnt >> (8 * e)) & 255);
         n  = 0;
         while (!f_out_valid(sel)) begin
            @(negedge clock);
            n++;
            if (n > BUDGET) begin
               n_fail++;
               $display("FAIL out_timeout: out_valid observed 0 expected 1");
               $fatal(1, "output timeout");
            end
         end
         check("out_data", f_out_data(sel), eb);
         check("out_last", f_out_last(sel), (e == cb - 1));
         if (e == 0) begin
            repeat (stall) begin
               @(negedge clock);
               check("stall_valid", f_out_valid(sel), 1);
               check("stall_data", f_out_data(sel), eb);
               check("stall_in_ready", f_in_ready(sel), 0);
            end
         end
         repeat ($urandom_range(0, 2)) @(negedge clock);
         check("hold_data", f_out_data(sel), eb);
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0;
      end
      check("done_valid", f_out_valid(sel), 0);
      check("done_data", f_out_data(sel), 0);
      check("rearm_in_ready", f_in_ready(sel), 1);
   endtask

   task automatic run_frame(input bit sel, input bq_t f, input int exp_cnt, input int stall, input bit gaps);
      send_frame(sel, f, 1'b1, gaps);
      check("latency_valid", f_out_valid(sel), 1);
      check("emit_in_ready", f_in_ready(sel), 0);
      recv_frame(sel, exp_cnt, stall);
   endtask

   initial begin
      bq_t f;
      int  cnt;
      int  hl;

      reset  = 1'b1;
      enable = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("rst_in_ready_a", in_ready_a, 0);
      check("rst_out_valid_a", out_valid_a, 0);
      check("rst_out_last_a", out_last_a, 0);
      check("rst_out_data_a", out_data_a, 0);
      check("rst_in_ready_b", in_ready_b, 0);
      check("rst_out_valid_b", out_valid_b, 0);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_in_ready", in_ready_a, 1);

      run_frame(0, cat(str2q("abcab"), str2q("abcabcab")), 2, 0, 0);
      run_frame(0, cat(str2q("hello"), str2q("xyz")), 0, 0, 0);
      run_frame(0, str2q("ab"), 0, 0, 0);
      run_frame(0, cat(str2q("aaaaa"), str2q("aaaaaa")), 2, 0, 0);
      run_frame(0, str2q("abcde"), 0, 0, 0);
      run_frame(0, cat(str2q("abcab"), str2q("abcab")), 1, 10, 0);
      run_frame(1, cat(str2q("aaaaa"), rep(8'h61, 300)), 255, 0, 0);

      // Abandon a frame mid-haystack with reset, then a clean frame must count from scratch
      send_frame(0, cat(str2q("abcab"), str2q("abca")), 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_in_ready", in_ready_a, 0);
      check("midrst_out_valid", out_valid_a, 0);
      reset = 1'b0;
      @(negedge clock);
      check("midrst_rearm", in_ready_a, 1);
      run_frame(0, cat(str2q("abcab"), str2q("abcab")), 1, 0, 1);

      repeat (25) begin
         f = {};
         if ($urandom_range(0, 7) == 0) begin
            hl = $urandom_range(1, SS);
            for (int i = 0; i < hl; i++) f.push_back(($urandom_range(0, 1) != 0) ? 8'h61 : 8'h62);
         end else begin
            hl = $urandom_range(0, 20);
            for (int i = 0; i < SS + hl; i++) f.push_back(($urandom_range(0, 1) != 0) ? 8'h61 : 8'h62);
         end
         cnt = model_count(f, 2);
         run_frame(0, f, cnt, $urandom_range(0, 3), 1);
      end

      repeat (4) begin
         f  = {};
         hl = $urandom_range(1, 40);
         for (int i = 0; i < SS + hl; i++) f.push_back(($urandom_range(0, 3) != 0) ? 8'h61 : 8'h62);
         cnt = model_count(f, 1);
         run_frame(1, f, cnt, $urandom_range(0, 3), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
